// File: rtl/rv32i_mult_pkg.sv
// rtl/rv32i_mult_pkg.sv - shared widths, state type and parameter check for the sequential multiplier
package rv32i_mult_pkg;

  localparam int MULT_OPERAND_W = 16;
  localparam int MULT_RESULT_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE_WAIT
  } mult_state_t;

  function automatic bit legal_bits_per_cycle(input int bits);
    return (bits == 1) || (bits == 2) || (bits == 4) || (bits == 8) || (bits == 16);
  endfunction

endpackage

// File: rtl/rv32i_mult_partial_product.sv
// rtl/rv32i_mult_partial_product.sv - multiplicand times one multiplier digit, shifted into place
module rv32i_mult_partial_product
  import rv32i_mult_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic [MULT_OPERAND_W-1:0] mcand,
  input  logic [BITS_PER_CYCLE-1:0] digit,
  input  logic [4:0]                shift,
  output logic [MULT_RESULT_W-1:0]  product
);

  logic [MULT_RESULT_W-1:0] wide_mcand;
  logic [MULT_RESULT_W-1:0] wide_digit;

  // 16 + BITS_PER_CYCLE never exceeds 32 bits, so the product cannot be truncated
  assign wide_mcand = MULT_RESULT_W'(mcand);
  assign wide_digit = MULT_RESULT_W'(digit);
  assign product    = (wide_mcand * wide_digit) << shift;

endmodule

// File: rtl/rv32i_seq_multiplier.sv
// rtl/rv32i_seq_multiplier.sv - iterative unsigned 16x16->32 shift-add multiplier with level-enable handshake
module rv32i_seq_multiplier
  import rv32i_mult_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic [MULT_OPERAND_W-1:0] i_operand_one,
  input  logic [MULT_OPERAND_W-1:0] i_operand_two,
  output logic                      o_valid,
  output logic [MULT_RESULT_W-1:0]  o_result,
  output logic                      o_busy
);

  localparam int ITERATIONS = MULT_OPERAND_W / BITS_PER_CYCLE;
  localparam int CNT_W      = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ITERATIONS - 1);

  generate
    if (!legal_bits_per_cycle(BITS_PER_CYCLE)) begin : g_bad_bits_per_cycle
      $error("rv32i_seq_multiplier: BITS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  mult_state_t               state_q, state_d;
  logic [MULT_RESULT_W-1:0]  acc_q, acc_d;
  logic [MULT_OPERAND_W-1:0] mcand_q, mcand_d;
  logic [MULT_OPERAND_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [MULT_RESULT_W-1:0]  result_q, result_d;
  logic                      valid_q, valid_d;
  logic [MULT_RESULT_W-1:0]  partial;
  logic [MULT_RESULT_W-1:0]  acc_sum;
  logic [4:0]                shift;

  assign shift = 5'(count_q) * 5'(BITS_PER_CYCLE);

  rv32i_mult_partial_product #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_partial_product (
    .mcand  (mcand_q),
    .digit  (mplier_q[BITS_PER_CYCLE-1:0]),
    .shift  (shift),
    .product(partial)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    result_d = result_q;
    valid_d  = 1'b0;
    acc_sum  = acc_q + partial;
    unique case (state_q)
      IDLE: begin
        if (i_en) begin
          mcand_d  = i_operand_one;
          mplier_d = i_operand_two;
          acc_d    = '0;
          count_d  = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = acc_sum;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        count_d  = count_q + CNT_W'(1);
        // A still-high enable parks in DONE_WAIT so it cannot start a second op
        if (count_q == LAST_COUNT) begin
          result_d = acc_sum;
          valid_d  = 1'b1;
          state_d  = i_en ? DONE_WAIT : IDLE;
        end
      end
      DONE_WAIT: begin
        if (!i_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_rv32i_seq_multiplier.sv
// tb/tb_rv32i_seq_multiplier.sv - self-checking bench for rv32i_seq_multiplier at BITS_PER_CYCLE 8 and 1
module tb_rv32i_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] op1 = '0;
  logic [15:0] op2 = '0;

  logic        valid8, valid1;
  logic [31:0] result8, result1;
  logic        busy8, busy1;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  rv32i_seq_multiplier #(.BITS_PER_CYCLE(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_operand_one(op1), .i_operand_two(op2),
    .o_valid(valid8), .o_result(result8), .o_busy(busy8)
  );

  rv32i_seq_multiplier #(.BITS_PER_CYCLE(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_operand_one(op1), .i_operand_two(op2),
    .o_valid(valid1), .o_result(result1), .o_busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level model: an accepted op completes a fixed number of edges later;
  // a completion seen with enable high must see enable low before the next accept.
  int          m_iter[2] = '{2, 16};
  int          m_remaining[2];
  bit          m_need_release[2];
  logic [31:0] m_product[2];
  logic [31:0] m_result[2];
  bit          m_valid[2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_remaining[d] = 0; m_need_release[d] = 0;
      m_product[d] = '0; m_result[d] = '0; m_valid[d] = 0;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0;
      if (rst) begin
        m_remaining[d] = 0; m_need_release[d] = 0; m_result[d] = '0;
      end else if (m_remaining[d] > 0) begin
        m_remaining[d]--;
        if (m_remaining[d] == 0) begin
          m_valid[d] = 1'b1;
          m_result[d] = m_product[d];
          m_need_release[d] = en;
        end
      end else if (m_need_release[d]) begin
        if (!en) m_need_release[d] = 1'b0;
      end else if (en) begin
        m_product[d] = 32'(op1) * 32'(op2);
        m_remaining[d] = m_iter[d];
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("model valid b8", {31'b0, valid8}, {31'b0, m_valid[0]});
      chk("model result b8", result8, m_result[0]);
      chk("model busy b8", {31'b0, busy8}, {31'b0, (m_remaining[0] > 0) || m_need_release[0]});
      chk("model valid b1", {31'b0, valid1}, {31'b0, m_valid[1]});
      chk("model result b1", result1, m_result[1]);
      chk("model busy b1", {31'b0, busy1}, {31'b0, (m_remaining[1] > 0) || m_need_release[1]});
    end
  end

  // Raise enable with operands, optionally swap operands mid-op, hold enable for
  // `hold` cycles, then drop it; reports latency, result and valid count per DUT.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input bit swap, input int hold,
                        output int lat8, output int lat1,
                        output logic [31:0] res8, output logic [31:0] res1,
                        output int n8, output int n1);
    lat8 = -1; lat1 = -1; res8 = '0; res1 = '0; n8 = 0; n1 = 0;
    @(negedge clk);
    en = 1'b1; op1 = a; op2 = b;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      if (swap && k == 1) begin op1 = 16'h0001; op2 = 16'h0001; end
      if (valid8) begin n8++; if (lat8 < 0) begin lat8 = k - 1; res8 = result8; end end
      if (valid1) begin n1++; if (lat1 < 0) begin lat1 = k - 1; res1 = result1; end end
    end
    en = 1'b0;
    @(negedge clk);
    if (valid8) n8++;
    if (valid1) n1++;
  endtask

  int          lat8, lat1, n8, n1;
  logic [31:0] res8, res1;

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset valid b8", {31'b0, valid8}, 32'd0);
    chk("reset result b8", result8, 32'd0);
    chk("reset busy b8", {31'b0, busy8}, 32'd0);
    chk("reset result b1", result1, 32'd0);
    chk("reset busy b1", {31'b0, busy1}, 32'd0);
    rst = 1'b0;
    checking = 1'b1;

    run_op(16'h1234, 16'h0010, 1'b0, 30, lat8, lat1, res8, res1, n8, n1);
    chk("b8 latency 0x1234*0x10", lat8, 32'd2);
    chk("b8 result 0x1234*0x10", res8, 32'h0001_2340);
    chk("b8 one valid while held", n8, 32'd1);
    chk("b1 result 0x1234*0x10", res1, 32'h0001_2340);

    run_op(16'hFFFF, 16'hFFFF, 1'b0, 20, lat8, lat1, res8, res1, n8, n1);
    chk("b1 latency ffff*ffff", lat1, 32'd16);
    chk("b1 result ffff*ffff", res1, 32'hFFFE_0001);
    chk("b8 result ffff*ffff", res8, 32'hFFFE_0001);
    chk("b1 one valid ffff*ffff", n1, 32'd1);

    run_op(16'h0000, 16'hABCD, 1'b0, 20, lat8, lat1, res8, res1, n8, n1);
    chk("b1 latency zero op", lat1, 32'd16);
    chk("b1 result zero op", res1, 32'd0);
    chk("b8 latency zero op", lat8, 32'd2);

    run_op(16'h0003, 16'h0005, 1'b1, 20, lat8, lat1, res8, res1, n8, n1);
    chk("b8 frozen operands", res8, 32'h0000_000F);
    chk("b1 frozen operands", res1, 32'h0000_000F);

    run_op(16'h0100, 16'h0100, 1'b0, 20, lat8, lat1, res8, res1, n8, n1);
    chk("b8 after release 0x100*0x100", res8, 32'h0001_0000);
    chk("b1 after release 0x100*0x100", res1, 32'h0001_0000);

    // Left shift by 12 expressed as a multiply by 0x1000
    run_op(16'h4F82, 16'h1000, 1'b0, 20, lat8, lat1, res8, res1, n8, n1);
    chk("b8 shift-left 12", res8, 32'h04F8_2000);
    chk("b1 shift-left 12", res1, 32'h04F8_2000);

    // Reset pulse one cycle into BUSY discards the op
    @(negedge clk);
    en = 1'b1; op1 = 16'h1111; op2 = 16'h2222;
    @(negedge clk);
    en = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst mid-op result b8", result8, 32'd0);
    chk("rst mid-op busy b8", {31'b0, busy8}, 32'd0);
    chk("rst mid-op result b1", result1, 32'd0);
    chk("rst mid-op busy b1", {31'b0, busy1}, 32'd0);
    n8 = 0; n1 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (valid8) n8++;
      if (valid1) n1++;
    end
    chk("no valid after rst b8", n8, 32'd0);
    chk("no valid after rst b1", n1, 32'd0);

    run_op(16'h0007, 16'h0009, 1'b0, 20, lat8, lat1, res8, res1, n8, n1);
    chk("b8 after rst 7*9", res8, 32'h0000_003F);
    chk("b1 after rst 7*9", res1, 32'h0000_003F);
    chk("b1 latency 7*9", lat1, 32'd16);

    repeat (3) @(negedge clk);
    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

endmodule

// File: doc/rv32i_seq_multiplier.md
Name: rv32i_seq_multiplier

Overview:
- Iterative unsigned 16x16->32 multiplier.
- Responder end of the multiplier interface driven by rv32I_multipler_shift_controlpath, which issues o_multiplier_en plus operands and waits for i_multiplier_valid/i_multiplier_result.
- Shift-add datapath retiring BITS_PER_CYCLE multiplier bits per clock, with fixed, operand-independent latency.
- One op in flight; level-enable handshake with a release requirement so a held enable never retriggers.

Parameters:
- BITS_PER_CYCLE, 8, multiplier bits retired per iteration; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- ITERATIONS, 16/BITS_PER_CYCLE, derived localparam, not overridable.

Ports:
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  request level from controlpath (o_multiplier_en).
- i_operand_one  in  16  multiplicand, unsigned.
- i_operand_two  in  16  multiplier, unsigned.
- o_valid  out  1  one-cycle result strobe (to i_multiplier_valid).
- o_result  out  32  product (to i_multiplier_result).
- o_busy  out  1  high in BUSY and DONE_WAIT.

Behaviour:
- Reset: state=IDLE, o_valid=0, o_result=0, o_busy=0, accumulator/count/operand registers=0. Reset wins over every other event, including mid-operation; the in-flight op is discarded and no o_valid is issued.
- FSM states: IDLE, BUSY, DONE_WAIT.
- IDLE: edge with i_en=1 -> capture both operands, clear accumulator, count=0, go to BUSY. i_en=0 -> stay.
- BUSY, each edge:
  - acc += (mcand * mplier[B-1:0]) << (count*B);
  - mplier >>= B; count++.
  - i_en and operand inputs are ignored; operands are frozen at capture.
- BUSY, final iteration (count==ITERATIONS-1): same edge loads o_result with the full product and sets o_valid=1. Go to DONE_WAIT if i_en=1, else IDLE.
- Latency: capture at edge N -> o_valid high during the cycle after edge N+ITERATIONS. Default: 2 cycles after capture. B=1: 16 cycles.
- o_valid: exactly one cycle per accepted op; cleared on the next edge in all states.
- o_result: holds its value until the next completion or reset.
- DONE_WAIT: stay while i_en=1; go to IDLE when i_en=0. A new op therefore needs i_en low for at least one edge.
- Arithmetic: fully unsigned; product width 32, so no overflow is possible. Partial sums are kept at 32 bits.
- Zero operand: no early termination; full latency applies.

Decomposition:
- Package rv32i_mult_pkg:
  - MULT_OPERAND_W=16, MULT_RESULT_W=32.
  - mult_state_t enum {IDLE, BUSY, DONE_WAIT}.
  - Legal BITS_PER_CYCLE check function.
- Sub-module rv32i_mult_partial_product (combinational):
  - Inputs: 16-bit multiplicand, B-bit digit, shift amount.
  - Output: 32-bit shifted partial product.
  - Top module holds FSM, counter, and accumulator.

Test Plan:
- B=8: i_en=1, op1=0x1234, op2=0x0010 -> o_valid single-cycle exactly 2 cycles after capture, o_result=0x00012340.
- B=1: op1=0xFFFF, op2=0xFFFF -> o_valid 16 cycles after capture, o_result=0xFFFE0001. Also op1=0, op2=0xABCD -> result 0 at the same 16-cycle latency.
- Operands changed to 0x0001/0x0001 during BUSY of op 0x0003*0x0005 -> o_result=0x0000000F.
- i_en held high 10 cycles after o_valid -> no second o_valid. Drop i_en one cycle, raise with 0x0100*0x0100 -> o_result=0x00010000.
- i_rst pulsed 1 cycle mid-BUSY -> o_valid never asserts; o_result=0 and o_busy=0 after the edge. Next op 0x0007*0x0009 -> 0x0000003F.
- Integrated with rv32I_multipler_shift_controlpath: shift opcode 0001 on 0x00104F82 by 12 completes with execute_data_valid, and the result matches the golden left-shift value.
